adc_averager: RTL and testbench
===============================

# adc_averager

Downstream stage of the ADC SPI manager. Consumes raw 32-bit conversion words over AXI Stream, extracts the signed 24-bit sample, and accumulates blocks of 2^N samples. It emits one block average per block as a 32-bit sign-extended AXI Stream word. The input is never back-pressured, so acquisition never stalls; results that cannot be delivered are dropped and counted.

## Interface
- `SAMPLE_WIDTH`, 24: signed sample width, taken from input bits [31:8]; bits [7:0] (common-mode byte) are discarded.
- `MAX_LOG2_AVG`, 8: largest allowed block exponent; the accumulator is SAMPLE_WIDTH+MAX_LOG2_AVG = 32 bits wide.
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `enable` in 1: averaging enable; low aborts the current partial block.
- `log2_avg` in 4: block exponent N; values above MAX_LOG2_AVG are clamped to MAX_LOG2_AVG.
- `drop_clear` in 1: synchronous clear of the drop counter.
- `s_axis_tdata` in 32: raw conversion word.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: tied to 1.
- `m_axis_tdata` out 32: block average, sign-extended.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `status` out 32: {drop_count[15:0], 4'b0, active_log2[3:0], sample_idx[7:0]}.

## Operation
- A sample is accepted on every cycle where s_axis_tvalid=1 and enable=1.
  - Samples presented while enable=0 are consumed and ignored.
- Block start: `active_log2` latches clamp(log2_avg) on the first accepted sample of a block.
  - log2_avg changes mid-block have no effect until the next block.
- Accumulation rules:
  - The first sample of a block loads the accumulator with the sign-extended sample.
  - Each later sample adds to the accumulator. `sample_idx` counts 0 .. 2^active_log2 − 1.
- Completion, on the sample where sample_idx == 2^active_log2 − 1:
  - result = (acc + sample) >>> active_log2, an arithmetic shift that rounds toward −∞.
  - The result is sign-extended to 32 bits.
  - The accumulator and sample_idx return to the block-start state.
- N = 0 is pass-through: every sample produces a result equal to the sign-extended sample.
- Output holding register (single entry):
  - A completion loads the register and sets m_axis_tvalid.
  - tvalid clears on a tvalid & tready handshake.
  - If a completion occurs while the register is full and tready=0, the new result is discarded, the held word is kept, and drop_count increments. drop_count saturates at 16'hFFFF.
  - Completion in the same cycle as a handshake: the new result loads, tvalid stays 1, no drop.
- Disable: enable=0 clears the accumulator, sample_idx and the block-start state. A pending output word is retained and still delivered.
- drop_clear=1 zeroes drop_count. If a drop happens in the same cycle, the clear wins.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0.
  - Accumulator=0, sample_idx=0, active_log2=0, drop_count=0.
  - s_axis_tready=1, including during reset.
- Latency: the sample accepted in cycle k that completes a block produces m_axis_tvalid=1 in cycle k+1.
- Throughput: one sample per clock sustained.
- Once m_axis_tvalid is asserted, tdata stays stable until the handshake; no retraction.
- Reset deassertion mid-block: the block restarts from an empty accumulator.
- Accumulator overflow is impossible by construction: 2^8 × (−2^23) fits in 32 bits signed.

## Structure
- The shared package `adc_pkg` holds:
  - SAMPLE_WIDTH and MAX_LOG2_AVG defaults.
  - Status field bit offsets: DropCountLsb=16, ActiveLog2Lsb=8, SampleIdxLsb=0.
  - Input field positions (sample [31:8], common-mode byte [7:0]).
- One sub-module, `axis_hold_reg`: the single-entry output register with load, drop-detect and handshake logic.
- Sample extraction, accumulator and block counter live in the top module.

## Test plan
- N=0, inputs 32'h7FFFFF_00 and 32'h800000_AB → outputs 32'h007FFFFF and 32'hFF800000, each one cycle after acceptance.
- N=2, samples 1, 2, 3, 5 (each in bits [31:8]) → single output 2 (11>>>2). Samples −1, −1, −1, −2 → output −2 (−5>>>2, rounds toward −∞).
- N=8, 256 samples of 24'h800000 back-to-back → output 32'hFF800000 after the 256th sample; no other outputs.
- N=0, tready=0, three samples 10, 20, 30:
  - Held word is 10 and drop_count = 2.
  - Then tready=1 → 10 delivered.
  - drop_clear → status[31:16] = 0.
- N=2, two samples accepted, then log2_avg changed to 1 → completion still after four samples.
- N=2, two samples accepted, then enable low for one cycle → next four samples form a fresh block.
- Pending output with tready=1, and a completion in the same cycle → new word held, tvalid stays high, drop_count unchanged.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, field positions and helpers for the ADC averaging stage.
package adc_pkg;

   localparam int unsigned SampleWidth  = 24;
   localparam int unsigned MaxLog2Avg   = 8;
   localparam int unsigned AccWidth     = SampleWidth + MaxLog2Avg;
   localparam int unsigned DataWidth    = 32;
   localparam int unsigned StatusWidth  = 32;
   localparam int unsigned IdxWidth     = 8;
   localparam int unsigned Log2Width    = 4;
   localparam int unsigned DropWidth    = 16;

   // Raw conversion word layout: signed sample over the common-mode byte
   localparam int unsigned SampleMsb    = 31;
   localparam int unsigned SampleLsb    = 8;
   localparam int unsigned CmMsb        = 7;
   localparam int unsigned CmLsb        = 0;

   localparam int unsigned DropCountLsb  = 16;
   localparam int unsigned ActiveLog2Lsb = 8;
   localparam int unsigned SampleIdxLsb  = 0;

   function automatic logic [Log2Width-1:0] clamp_log2(input logic [Log2Width-1:0] n);
      return (32'(n) > MaxLog2Avg) ? Log2Width'(MaxLog2Avg) : n;
   endfunction

endpackage

// File: rtl/adc_averager_if.sv
// AXI Stream link carrying 32-bit ADC words between pipeline stages.
interface adc_averager_if;
   import adc_pkg::*;

   logic [DataWidth-1:0] tdata;
   logic                 tvalid;
   logic                 tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_hold_reg.sv
// Single-entry AXI Stream output register; discards and counts results that arrive while full.
module axis_hold_reg
   import adc_pkg::*;
(
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 load,
   input  logic [DataWidth-1:0] load_data,
   input  logic                 drop_clear,
   adc_averager_if.master       m_axis,
   output logic [DropWidth-1:0] drop_count
);

   logic [DataWidth-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic [DropWidth-1:0] drop_q, drop_d;
   logic                 handshake_c;
   logic                 drop_c;

   always_comb begin
      data_d      = data_q;
      valid_d     = valid_q;
      drop_d      = drop_q;
      handshake_c = valid_q & m_axis.tready;
      drop_c      = 1'b0;

      if (load) begin
         // A word leaving this cycle frees the slot for the new one
         if (!valid_q || handshake_c) begin
            data_d  = load_data;
            valid_d = 1'b1;
         end else begin
            drop_c = 1'b1;
         end
      end else if (handshake_c) begin
         valid_d = 1'b0;
      end

      if (drop_clear) begin
         drop_d = '0;
      end else if (drop_c && (drop_q != {DropWidth{1'b1}})) begin
         drop_d = drop_q + DropWidth'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   assign m_axis.tdata  = data_q;
   assign m_axis.tvalid = valid_q;
   assign drop_count    = drop_q;

endmodule

// File: rtl/adc_averager.sv
// Block averager: accumulates 2^N signed ADC samples and emits their floor-average.
module adc_averager
   import adc_pkg::*;
(
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   enable,
   input  logic [Log2Width-1:0]   log2_avg,
   input  logic                   drop_clear,
   adc_averager_if.slave          s_axis,
   adc_averager_if.master         m_axis,
   output logic [StatusWidth-1:0] status
);

   logic signed [AccWidth-1:0]    acc_q, acc_d;
   logic [IdxWidth-1:0]           idx_q, idx_d;
   logic [Log2Width-1:0]          active_log2_q, active_log2_d;

   logic signed [SampleWidth-1:0] sample_c;
   logic signed [AccWidth-1:0]    sum_c;
   logic signed [AccWidth-1:0]    result_c;
   logic [Log2Width-1:0]          log2_eff_c;
   logic [IdxWidth-1:0]           last_idx_c;
   logic                          accept_c;
   logic                          first_c;
   logic                          complete_c;
   logic [DropWidth-1:0]          drop_count;

   // Input is never back-pressured
   assign s_axis.tready = 1'b1;

   always_comb begin
      acc_d         = acc_q;
      idx_d         = idx_q;
      active_log2_d = active_log2_q;

      sample_c   = signed'(s_axis.tdata[SampleMsb:SampleLsb]);
      accept_c   = s_axis.tvalid & enable;
      first_c    = (idx_q == '0);
      // The exponent is sampled only at block start, later changes wait for the next block
      log2_eff_c = first_c ? clamp_log2(log2_avg) : active_log2_q;
      last_idx_c = IdxWidth'((AccWidth'(1) << log2_eff_c) - AccWidth'(1));
      sum_c      = first_c ? AccWidth'(sample_c) : acc_q + AccWidth'(sample_c);
      result_c   = sum_c >>> log2_eff_c;
      complete_c = accept_c & (idx_q == last_idx_c);

      if (!enable) begin
         acc_d = '0;
         idx_d = '0;
      end else if (accept_c) begin
         if (first_c) begin
            active_log2_d = log2_eff_c;
         end
         if (complete_c) begin
            acc_d = '0;
            idx_d = '0;
         end else begin
            acc_d = sum_c;
            idx_d = idx_q + IdxWidth'(1);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_q         <= '0;
         idx_q         <= '0;
         active_log2_q <= '0;
      end else begin
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         active_log2_q <= active_log2_d;
      end
   end

   axis_hold_reg u_hold (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .load       (complete_c),
      .load_data  (DataWidth'(result_c)),
      .drop_clear (drop_clear),
      .m_axis     (m_axis),
      .drop_count (drop_count)
   );

   always_comb begin
      status                                  = '0;
      status[DropCountLsb  +: DropWidth]      = drop_count;
      status[ActiveLog2Lsb +: Log2Width]      = active_log2_q;
      status[SampleIdxLsb  +: IdxWidth]       = idx_q;
   end

endmodule

// File: tb/tb_adc_averager.sv
// Directed bench for adc_averager with hand-computed expected averages.
module tb_adc_averager;
   import adc_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic [3:0]  log2_avg;
   logic        drop_clear;
   logic [31:0] status;

   int total = 0;
   int bad   = 0;

   adc_averager_if s_if ();
   adc_averager_if m_if ();

   always #5 aclk = ~aclk;

   adc_averager dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .enable     (enable),
      .log2_avg   (log2_avg),
      .drop_clear (drop_clear),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .status     (status)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_raw(input logic [31:0] w);
      s_if.tdata  = w;
      s_if.tvalid = 1'b1;
      step();
      s_if.tvalid = 1'b0;
   endtask

   task automatic send(input logic [23:0] s);
      send_raw({s, 8'h5A});
   endtask

   initial begin
      int early;
      aresetn     = 1'b0;
      enable      = 1'b1;
      log2_avg    = 4'd0;
      drop_clear  = 1'b0;
      s_if.tdata  = '0;
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;

      #1;
      check("tready_in_reset", 32'(s_if.tready), 32'd1);
      step();
      step();
      check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
      check("rst_tdata", m_if.tdata, 32'h0);
      check("rst_status", status, 32'h0);
      aresetn = 1'b1;
      step();

      // N=0 pass-through, one cycle latency, back-to-back with handshake
      log2_avg = 4'd0;
      send_raw(32'h7FFFFF00);
      check("n0_pos_valid", 32'(m_if.tvalid), 32'd1);
      check("n0_pos_data", m_if.tdata, 32'h007FFFFF);
      send_raw(32'h800000AB);
      check("n0_neg_valid", 32'(m_if.tvalid), 32'd1);
      check("n0_neg_data", m_if.tdata, 32'hFF800000);
      step();
      check("n0_drained", 32'(m_if.tvalid), 32'd0);

      // N=2 positive block
      log2_avg = 4'd2;
      send(24'd1);
      send(24'd2);
      send(24'd3);
      check("n2_no_early", 32'(m_if.tvalid), 32'd0);
      check("n2_status_mid", status, 32'h00000203);
      send(24'd5);
      check("n2_pos_valid", 32'(m_if.tvalid), 32'd1);
      check("n2_pos_data", m_if.tdata, 32'd2);
      check("n2_idx_reset", status, 32'h00000200);
      step();

      // N=2 negative block rounds toward minus infinity
      send(24'hFFFFFF);
      send(24'hFFFFFF);
      send(24'hFFFFFF);
      send(24'hFFFFFE);
      check("n2_neg_data", m_if.tdata, 32'hFFFFFFFE);
      step();

      // Exponent above the maximum is clamped
      log2_avg = 4'hF;
      send(24'd1);
      check("clamp_status", status, 32'h00000801);
      enable = 1'b0;
      step();
      enable = 1'b1;
      check("abort_idx", status, 32'h00000800);

      // N=8 long block of most-negative samples
      log2_avg = 4'd8;
      early = 0;
      for (int i = 0; i < 256; i++) begin
         send(24'h800000);
         if (i < 255 && m_if.tvalid) early++;
      end
      check("n8_no_early", 32'(early), 32'd0);
      check("n8_valid", 32'(m_if.tvalid), 32'd1);
      check("n8_data", m_if.tdata, 32'hFF800000);
      step();
      check("n8_single", 32'(m_if.tvalid), 32'd0);

      // Drops while the holding register is full
      log2_avg    = 4'd0;
      m_if.tready = 1'b0;
      send(24'd10);
      send(24'd20);
      send(24'd30);
      check("drop_held", m_if.tdata, 32'd10);
      check("drop_valid", 32'(m_if.tvalid), 32'd1);
      check("drop_count2", 32'(status[31:16]), 32'd2);
      m_if.tready = 1'b1;
      step();
      check("drop_delivered", 32'(m_if.tvalid), 32'd0);
      drop_clear = 1'b1;
      step();
      drop_clear = 1'b0;
      check("drop_cleared", 32'(status[31:16]), 32'd0);

      // Mid-block exponent change has no effect until next block
      log2_avg = 4'd2;
      send(24'd8);
      send(24'd8);
      log2_avg = 4'd1;
      send(24'd8);
      check("chg_no_early", 32'(m_if.tvalid), 32'd0);
      check("chg_status", status, 32'h00000203);
      send(24'd8);
      check("chg_valid", 32'(m_if.tvalid), 32'd1);
      check("chg_data", m_if.tdata, 32'd8);
      step();

      // Disable aborts a partial block; samples while disabled are ignored
      log2_avg = 4'd2;
      send(24'd100);
      send(24'd100);
      enable = 1'b0;
      send(24'd999);
      enable = 1'b1;
      check("dis_idx", 32'(status[7:0]), 32'd0);
      send(24'd4);
      send(24'd8);
      check("dis_fresh_a", 32'(m_if.tvalid), 32'd0);
      send(24'd12);
      check("dis_fresh_b", 32'(m_if.tvalid), 32'd0);
      send(24'd16);
      check("dis_valid", 32'(m_if.tvalid), 32'd1);
      check("dis_data", m_if.tdata, 32'd10);
      step();

      // Completion coinciding with a handshake replaces the word without a drop
      log2_avg = 4'd0;
      send(24'd5);
      check("hs_first", m_if.tdata, 32'd5);
      send(24'd6);
      check("hs_valid", 32'(m_if.tvalid), 32'd1);
      check("hs_data", m_if.tdata, 32'd6);
      check("hs_no_drop", 32'(status[31:16]), 32'd0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
